wb_regfile: RTL
===============

# wb_regfile

Write-back stage and integer register file for the 5-stage RISC-V pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value (load data or ALU result), and commits it to a 32 x 32-bit register file with x0 hardwired to zero. It provides the two combinational read ports used by the ID stage and a committed-write counter for performance/debug.

## Interface
Parameters:
- COUNT_W, 32, width of the committed-write counter `wb_count`.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- memtoreg_wb  input  1  1 = write back `read_data_wb`, 0 = write back `alu_result_wb`.
- regwrite_wb  input  1  write enable for the write-back.
- read_data_wb  input  32  load data from MEM/WB.
- alu_result_wb  input  32  ALU result from MEM/WB.
- rd_wb  input  5  destination register index.
- rs1_addr  input  5  read port 1 index.
- rs2_addr  input  5  read port 2 index.
- rs1_data  output  32  read port 1 data (combinational).
- rs2_data  output  32  read port 2 data (combinational).
- wb_data  output  32  selected write-back value (combinational, valid every cycle).
- wb_count  output  COUNT_W  number of committed register writes since reset.

## Operation
- `wb_data` = `memtoreg_wb ? read_data_wb : alu_result_wb`, regardless of `regwrite_wb`.
- Commit condition: `regwrite_wb == 1 && rd_wb != 0 && reset == 0`. On a commit, register `rd_wb` <= `wb_data`.
- Writes with `rd_wb == 0` are discarded. x0 reads as 0 on both ports at all times.
- Read ports are asynchronous: `rs*_data` = regs[`rs*_addr`], or 0 if addr == 0. The bypass rule is under Configuration.
- `wb_count` increments by 1 on every commit, wraps from 2^COUNT_W-1 to 0, and holds otherwise. Writes to x0 are not counted.
- Both read ports may address the same register; both return the same value.

## Timing
- Reset (synchronous): at a posedge with `reset == 1`, all 31 registers and `wb_count` clear to 0. Reset overrides a simultaneous commit, and that write is lost.
- Reset values: `rs1_data` = `rs2_data` = 0 after the reset edge for any address; `wb_count` = 0. `wb_data` has no reset because it is combinational from its inputs.
- Reset asserted mid-operation clears all state at the next edge. No partial state is retained.
- Write latency: a commit at edge N is visible on the read ports from edge N onward, i.e. in cycle N+1 without bypass.
- `wb_count` reflects a commit one cycle after that commit's edge.
- There is no handshake and no stall. One commit is possible per cycle, and every cycle with the commit condition true commits.

## Configuration
- `WB_BYPASS_EN` defined: the register file is write-through. When the commit condition is true in the current cycle and `rs*_addr == rd_wb`, the port returns `wb_data` combinationally instead of the stored value. The ID stage therefore sees a same-cycle WB result, and no WB-to-ID forwarding path is needed.
- `WB_BYPASS_EN` undefined: the ports always return the stored value. A same-cycle read of `rd_wb` returns the old contents, and the hazard/forwarding unit must cover the WB-to-ID case.
- The x0 rule applies in both modes. Reads of address 0 are never bypassed.

## Test plan
- Reset then read: assert reset for 1 edge, then read all 32 addresses on both ports -> all 0; `wb_count` = 0.
- ALU write-back: regwrite=1, memtoreg=0, alu_result=0xDEADBEEF, rd=5, one edge -> rs1_addr=5 reads 0xDEADBEEF next cycle; `wb_count` = 1.
- Load write-back and x0: memtoreg=1, read_data=0x12345678, rd=7, then the same with rd=0 and read_data=0xFFFFFFFF -> x7 = 0x12345678; x0 reads 0; `wb_count` = 1 (x0 write not counted).
- Same-cycle read of write target: x3 = 0x11, then commit 0x22 to rd=3 while rs2_addr=3 -> with `WB_BYPASS_EN` rs2_data = 0x22 in the write cycle; without it, 0x11 in the write cycle and 0x22 after the edge.
- Reset vs. write collision: reset=1 and regwrite=1, rd=9, alu_result=0xAA on the same edge -> x9 reads 0 and `wb_count` = 0.
- Counter wrap: COUNT_W=4, 17 consecutive commits to rd=1 -> `wb_count` reaches 15, then 0, then 1.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux and 32 x 32-bit integer register file (x0 hardwired to zero).
// Two asynchronous read ports for ID and a committed-write counter for perf/debug.
// Optional feature macro: WB_BYPASS_EN makes the register file write-through, so a same-cycle
// commit is visible on the read ports.

module wb_regfile #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memtoreg_wb,
  input  logic               regwrite_wb,
  input  logic [31:0]        read_data_wb,
  input  logic [31:0]        alu_result_wb,
  input  logic [4:0]         rd_wb,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  output logic [31:0]        rs1_data,
  output logic [31:0]        rs2_data,
  output logic [31:0]        wb_data,
  output logic [COUNT_W-1:0] wb_count
);

  // x0 has no storage; entries 1..31 only.
  logic [31:0]        regs_q [31:1];
  logic [COUNT_W-1:0] count_q, count_d;
  logic               commit;

  // Write-back select and commit qualification.
  always_comb begin
    wb_data = memtoreg_wb ? read_data_wb : alu_result_wb;
    commit  = regwrite_wb && (rd_wb != 5'd0) && !reset;
  end

  // Register file update; reset wins over a simultaneous commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (commit) begin
      regs_q[rd_wb] <= wb_data;
    end
  end

  // Committed-write counter next state, wraps naturally.
  always_comb begin
    count_d = count_q;
    if (commit) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign wb_count = count_q;

  // Asynchronous read ports; address 0 always reads zero and is never bypassed.
  always_comb begin
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    if (rs1_addr != 5'd0) begin
      rs1_data = regs_q[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      rs2_data = regs_q[rs2_addr];
    end
`ifdef WB_BYPASS_EN
    // commit already implies rd_wb != 0, so x0 cannot be bypassed here.
    if (commit && (rs1_addr == rd_wb)) begin
      rs1_data = wb_data;
    end
    if (commit && (rs2_addr == rd_wb)) begin
      rs2_data = wb_data;
    end
`else
`endif
  end

endmodule
